// File: rtl/counter_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | counter_sched_pkg : shared types and constants for the counter scheduler |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package counter_sched_pkg;

  localparam int N_CH   = 4;
  localparam int CH_W   = 2;
  localparam int TURN_W = 32;

  localparam logic [CH_W-1:0] CH_Z0 = 2'd0;
  localparam logic [CH_W-1:0] CH_Y1 = 2'd1;
  localparam logic [CH_W-1:0] CH_X2 = 2'd2;
  localparam logic [CH_W-1:0] CH_W3 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REPORT = 2'd1,
    ST_ACK    = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  // Round-robin successor of a channel index among n_ch channels.
  function automatic logic [CH_W-1:0] ch_next(input logic [CH_W-1:0] ch, input int n_ch);
    if (int'(ch) >= n_ch - 1) return CH_Z0;
    return ch + CH_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/counter_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | counter_sched_if : configuration write port and terminal-event handshake |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface counter_sched_if;
  import counter_sched_pkg::*;

  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [TURN_W-1:0] cfg_turn;
  logic              cfg_bar;
  logic              cfg_auto;

  logic              evt_valid;
  logic [CH_W-1:0]   evt_ch;
  logic              evt_ready;

  modport master (
    output cfg_wr, cfg_ch, cfg_turn, cfg_bar, cfg_auto, evt_ready,
    input  evt_valid, evt_ch
  );

  modport slave (
    input  cfg_wr, cfg_ch, cfg_turn, cfg_bar, cfg_auto, evt_ready,
    output evt_valid, evt_ch
  );
endinterface
`default_nettype wire

// File: rtl/counter_sched_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_pick : combinational round-robin pick, lowest request at/after ptr    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rr_pick #(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]                  req,
  input  logic [counter_sched_pkg::CH_W-1:0] ptr,
  output logic [N_CH-1:0]                  grant,
  output logic                             valid
);
  import counter_sched_pkg::*;

  localparam int SUM_W = CH_W + 1;

  logic [SUM_W-1:0] w_sum;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    w_sum = '0;
    // Scan farthest offset first so the nearest requester is the last writer.
    for (int i = N_CH - 1; i >= 0; i--) begin
      w_sum = {1'b0, ptr} + SUM_W'(i);
      if (w_sum >= SUM_W'(N_CH)) w_sum = w_sum - SUM_W'(N_CH);
      if (req[w_sum[CH_W-1:0]]) begin
        grant                   = '0;
        grant[w_sum[CH_W-1:0]]  = 1'b1;
        valid                   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/counter_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | counter_sched : counter channel config, tick prescaler, event arbiter    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module counter_sched #(
  parameter int N_CH  = counter_sched_pkg::N_CH,
  parameter int DIV_W = 16
) (
  input  logic                sysclk,
  input  logic                foo_card_n,
  counter_sched_if.slave      bus,
  input  logic [N_CH-1:0]     cfg_en,
  input  logic [DIV_W-1:0]    tick_div,
  input  logic [N_CH-1:0]     ch_cwm,
  output logic [N_CH-1:0]     ch_baz,
  output logic [N_CH-1:0]     ch_blrb,
  output logic [N_CH-1:0]     ch_zz1pb,
  output logic [N_CH-1:0]     ch_bar,
  output logic [32*N_CH-1:0]  ch_turn
);
  import counter_sched_pkg::*;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CH_W-1:0]   r_grant;
  logic [CH_W-1:0]   r_ptr;
  logic [DIV_W-1:0]  r_cnt;
  logic              r_live;
  logic [31:0]       r_turn [N_CH];
  logic [N_CH-1:0]   r_bar;
  logic [N_CH-1:0]   r_auto;
  logic [N_CH-1:0]   r_baz_cfg;

  logic [N_CH-1:0]   w_pick_oh;
  logic              w_pick_valid;
  logic [CH_W-1:0]   w_pick_idx;
  logic              w_cfg_hit;
  logic              w_tick;
  logic              w_evt_valid;
  logic [N_CH-1:0]   w_zz1pb;
  logic [N_CH-1:0]   w_ack_baz;

  // Channel configuration registers and the load pulse that follows a write.
  always_ff @(posedge sysclk or negedge foo_card_n) begin
    if (!foo_card_n) begin
      for (int k = 0; k < N_CH; k++) r_turn[k] <= '0;
      r_bar     <= '0;
      r_auto    <= '0;
      r_baz_cfg <= '0;
    end else begin
      r_baz_cfg <= '0;
      if (bus.cfg_wr) begin
        r_turn[bus.cfg_ch]    <= bus.cfg_turn;
        r_bar[bus.cfg_ch]     <= bus.cfg_bar;
        r_auto[bus.cfg_ch]    <= bus.cfg_auto;
        r_baz_cfg[bus.cfg_ch] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_turn
    assign ch_turn[32*k +: 32] = r_turn[k];
  end

  // Prescaler; >= lets a shrinking tick_div wrap immediately instead of running to 2^DIV_W.
  always_ff @(posedge sysclk or negedge foo_card_n) begin
    if (!foo_card_n) begin
      r_cnt  <= '0;
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
      r_cnt  <= (r_cnt >= tick_div) ? '0 : r_cnt + DIV_W'(1);
    end
  end

  assign w_tick = r_live && (r_cnt == tick_div);

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req   (ch_cwm),
    .ptr   (r_ptr),
    .grant (w_pick_oh),
    .valid (w_pick_valid)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_pick_oh[i]) w_pick_idx = CH_W'(i);
    end
  end

  always_ff @(posedge sysclk or negedge foo_card_n) begin
    if (!foo_card_n) r_state <= ST_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_pick_valid) w_state_nxt = ST_REPORT;
      ST_REPORT: if (bus.evt_ready) w_state_nxt = ST_ACK;
      ST_ACK:    w_state_nxt = ST_SETTLE;
      ST_SETTLE: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge foo_card_n) begin
    if (!foo_card_n) begin
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      if (r_state == ST_IDLE && w_pick_valid) r_grant <= w_pick_idx;
      if (r_state == ST_SETTLE)               r_ptr   <= ch_next(r_grant, N_CH);
    end
  end

  // A write to the granted channel during ACK absorbs the rearm pulse so the
  // single load that follows carries the freshly written turn.
  assign w_cfg_hit = bus.cfg_wr && (bus.cfg_ch == r_grant);

  always_comb begin
    w_evt_valid = 1'b0;
    w_zz1pb     = '1;
    w_ack_baz   = '0;
    case (r_state)
      ST_REPORT: w_evt_valid = 1'b1;
      ST_ACK: begin
        w_zz1pb[r_grant] = 1'b0;
        if (!r_bar[r_grant] && r_auto[r_grant] && !w_cfg_hit) w_ack_baz[r_grant] = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.evt_valid = w_evt_valid;
  assign bus.evt_ch    = r_grant;
  assign ch_zz1pb      = w_zz1pb;
  assign ch_baz        = r_baz_cfg | w_ack_baz;
  assign ch_blrb       = (w_tick ? cfg_en : '0) & ~ch_baz;
  assign ch_bar        = r_bar;

endmodule
`default_nettype wire
